mem_bus_arbiter: RTL

//  Upstream stage of the mapped-register bank: arbitrates data-memory accesses from the core (A) and the

---
 rtl/mem_bus_arbiter_pkg.sv | 26 ++
 rtl/mem_bus_arbiter_rr_arbiter2.sv | 45 ++++
 rtl/mem_bus_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// requester identifiers and the mapped-register address window.
package mem_bus_arbiter_pkg;

   // Access sequencing states; exported unchanged on the debug state output.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } stateT;

   // Requester identity: A is the core, B is the debug/scan port.
   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } portIdT;

   // Upper two address bits selecting the mapped-register window.
   localparam logic [1:0] MAP_SEL = 2'b11;

   // True when a word address falls in the mapped-register window.
   function automatic logic isMapped(input logic [15:0] addr);
      return addr[15:14] == MAP_SEL;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-way request arbiter with a remembered last winner. With RR_EN set,
// simultaneous requests go to the port that did not win last time; with
// RR_EN clear, port A always wins a tie. The last winner starts as B so that
// A is favoured on the first contested grant after reset.
module rr_arbiter2
   import mem_bus_arbiter_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   aReq,
   input  logic   bReq,
   input  logic   take,
   output logic   grantValid,
   output portIdT grantId
);

   portIdT lastGrant;

   // Combinational winner selection from the current requests and history.
   always_comb begin
      grantValid = aReq | bReq;
      grantId    = PORT_A;
      if (aReq && bReq) begin
         if (RR_EN) begin
            grantId = (lastGrant == PORT_A) ? PORT_B : PORT_A;
         end else begin
            grantId = PORT_A;
         end
      end else if (bReq) begin
         grantId = PORT_B;
      end
   end

   // Remember the winner whenever the consumer actually takes a grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         lastGrant <= PORT_B;
      end else if (take && grantValid) begin
         lastGrant <= grantId;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Data-memory arbiter in front of the mapped-register bank. Picks one of the
// core (A) or debug (B) requests, runs it through IDLE -> ACCESS -> DONE and
// steers it to the mapped-register bus (addr[15:14] == 2'b11, 14-bit offset)
// or to external SRAM, returning read data alongside a one-cycle ack.
//
// Requester handshake: a port raises its req together with addr/wrEn/data and
// holds req until its ack. The request is sampled only in the IDLE cycle that
// grants it; afterwards the access runs entirely from internal hold registers,
// so later changes (including dropping req) do not alter or abort it. The ack
// is high for exactly one cycle, and rdData is meaningful only while ack is
// high (it otherwise keeps the last delivered value).
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int SRAM_RD_LAT = 1,    // SRAM read latency in cycles, 0..3
   parameter bit RR_EN       = 1'b1  // 1: round-robin ties, 0: A wins ties
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_aReq,
   input  logic [15:0] i_aAddr,
   input  logic        i_aWrEn,
   input  logic [15:0] i_aData,
   output logic        o_aAck,
   output logic [15:0] o_aRdData,
   input  logic        i_bReq,
   input  logic [15:0] i_bAddr,
   input  logic        i_bWrEn,
   input  logic [15:0] i_bData,
   output logic        o_bAck,
   output logic [15:0] o_bRdData,
   output logic [13:0] o_memAddr,
   output logic [15:0] o_memDataIn,
   output logic        o_memWrEn,
   input  logic [15:0] i_memDataOut,
   output logic [15:0] o_sramAddr,
   output logic [15:0] o_sramData,
   output logic        o_sramWrEn,
   input  logic [15:0] i_sramData,
   output stateT       o_dbgState
);

   // Value of the wait counter in the last ACCESS cycle of an SRAM read.
   localparam logic [1:0] RD_LAST = 2'(SRAM_RD_LAT);

   stateT       state;
   stateT       nextState;
   logic        grantValid;
   portIdT      grantId;
   logic [15:0] holdAddr;
   logic [15:0] holdData;
   logic        holdWrEn;
   logic        holdMap;
   portIdT      holdOwner;
   logic [1:0]  waitCnt;
   logic [15:0] rdHold;
   logic [15:0] aRdLast;
   logic [15:0] bRdLast;
   logic        accessLast;

   rr_arbiter2 #(
      .RR_EN(RR_EN)
   ) uArb (
      .clk       (i_clk),
      .rst       (i_rst),
      .aReq      (i_aReq),
      .bReq      (i_bReq),
      .take      (state == ST_IDLE),
      .grantValid(grantValid),
      .grantId   (grantId)
   );

   // Writes and mapped reads need one ACCESS cycle; SRAM reads wait out the latency.
   assign accessLast = (state == ST_ACCESS) &&
                       (holdWrEn || holdMap || (waitCnt == RD_LAST));

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state selection.
   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE:   if (grantValid) nextState = ST_ACCESS;
         ST_ACCESS: if (accessLast) nextState = ST_DONE;
         ST_DONE:   nextState = ST_IDLE;
         default:   nextState = ST_IDLE;
      endcase
   end

   // Request latching, SRAM wait counting, read capture and per-port rdData history.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         holdAddr  <= '0;
         holdData  <= '0;
         holdWrEn  <= 1'b0;
         holdMap   <= 1'b0;
         holdOwner <= PORT_A;
         waitCnt   <= '0;
         rdHold    <= '0;
         aRdLast   <= '0;
         bRdLast   <= '0;
      end else begin
         if (state == ST_IDLE && grantValid) begin
            holdOwner <= grantId;
            if (grantId == PORT_A) begin
               holdAddr <= i_aAddr;
               holdData <= i_aData;
               holdWrEn <= i_aWrEn;
               holdMap  <= isMapped(i_aAddr);
            end else begin
               holdAddr <= i_bAddr;
               holdData <= i_bData;
               holdWrEn <= i_bWrEn;
               holdMap  <= isMapped(i_bAddr);
            end
         end
         if (state == ST_ACCESS && !accessLast) begin
            waitCnt <= waitCnt + 2'd1;
         end else begin
            waitCnt <= '0;
         end
         if (accessLast) begin
            rdHold <= holdWrEn ? 16'h0000 : (holdMap ? i_memDataOut : i_sramData);
         end
         if (state == ST_DONE) begin
            if (holdOwner == PORT_A) begin
               aRdLast <= rdHold;
            end else begin
               bRdLast <= rdHold;
            end
         end
      end
   end

   // Bus drive during ACCESS, ack/rdData during DONE, everything else idle.
   always_comb begin
      o_aAck      = 1'b0;
      o_bAck      = 1'b0;
      o_aRdData   = aRdLast;
      o_bRdData   = bRdLast;
      o_memAddr   = '0;
      o_memDataIn = '0;
      o_memWrEn   = 1'b0;
      o_sramAddr  = '0;
      o_sramData  = '0;
      o_sramWrEn  = 1'b0;
      o_dbgState  = state;
      if (state == ST_ACCESS) begin
         if (holdMap) begin
            o_memAddr   = holdAddr[13:0];
            o_memDataIn = holdData;
            o_memWrEn   = holdWrEn && (waitCnt == 2'd0);
         end else begin
            o_sramAddr  = holdAddr;
            o_sramData  = holdData;
            o_sramWrEn  = holdWrEn && (waitCnt == 2'd0);
         end
      end else if (state == ST_DONE) begin
         if (holdOwner == PORT_A) begin
            o_aAck    = 1'b1;
            o_aRdData = rdHold;
         end else begin
            o_bAck    = 1'b1;
            o_bRdData = rdHold;
         end
      end
   end

endmodule
